strip_header: RTL and testbench
===============================

# strip_header

Receive-side counterpart of the header-insertion stage. Consumes a stream in which every packet is preceded by a one-beat header carrying the packet length in bytes. Strips the header, forwards the payload unchanged, and measures the payload's actual byte count. Emits one status word per packet on a side stream, flagging any mismatch between the declared and actual length.

## Interface
Parameters:
- DW, 128, data width in bits; multiple of 8, minimum 16.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- axis_in_tdata  in  DW  header beat or payload beat.
- axis_in_tkeep  in  DW/8  byte enables; ignored on header beats.
- axis_in_tlast  in  1  last payload beat.
- axis_in_tvalid  in  1  input beat is valid.
- axis_in_tready  out  1  input beat is accepted.
- axis_out_tdata  out  DW  payload data.
- axis_out_tkeep  out  DW/8  payload byte enables.
- axis_out_tlast  out  1  last payload beat.
- axis_out_tvalid  out  1  payload beat is valid.
- axis_out_tready  in  1  downstream accepts the payload beat.
- axis_stat_tdata  out  32  per-packet status word.
- axis_stat_tvalid  out  1  status word is valid.
- axis_stat_tready  in  1  downstream accepts the status word.

## Operation
- FSM states: HDR, PAYLOAD. Reset enters HDR.
- **HDR**
  - axis_in_tready = !stat_valid | axis_stat_tready, so the single status slot is free or draining.
  - axis_out_tvalid = 0.
  - On handshake, latch exp_len = axis_in_tdata[15:0]; bits above 15 are ignored.
  - Clear byte_cnt.
  - If the header beat carries tlast=1 (runt), load a status word with RUNT set and measured length 0, and stay in HDR.
  - Otherwise go to PAYLOAD.
- **PAYLOAD**: combinational pass-through.
  - axis_out_{tdata,tkeep,tlast,tvalid} = axis_in_*.
  - axis_in_tready = axis_out_tready.
- **Byte count**
  - Each handshaken payload beat adds popcount(tkeep) to byte_cnt.
  - byte_cnt is 17 bits internally.
  - tkeep need not be contiguous; count set bits only.
- **Status load**: on the tlast handshake, compute final = byte_cnt + popcount(tkeep), then load the status register:
  - [15:0] = min(final, 65535).
  - [16] MISMATCH = (final != exp_len).
  - [17] RUNT.
  - [18] OVERFLOW = (final > 65535); MISMATCH is also set when OVERFLOW is set.
  - [31:19] = 0.
  - Return to HDR.
- **Status output**
  - stat_valid stays high until axis_stat_tready.
  - The status word never changes while valid and unaccepted.
  - If a new status is loaded in the same cycle the old one is accepted, the new word replaces it and stat_valid stays 1.
- Payload flow never waits on the status stream; only header acceptance does.

## Timing
- Reset values:
  - fsm = HDR.
  - stat_valid = 0; status register = 0.
  - byte_cnt = 0; exp_len = 0.
- Output values while reset is high:
  - axis_in_tready = 0, axis_out_tvalid = 0, axis_stat_tvalid = 0.
  - axis_out_tdata, axis_out_tkeep, axis_out_tlast = 0.
- Payload latency is 0 cycles (combinational). The header beat costs one input cycle and produces no output beat.
- axis_stat_tvalid rises the cycle after the tlast (or runt-header) handshake.
- Back-to-back packets:
  - The next header can be accepted the cycle after tlast if the status slot is free or draining.
  - Sustained throughput is one beat per cycle when both downstreams are always ready.
- Reset mid-packet abandons the packet: no status word is produced, and the FSM returns to HDR. The first beat after reset is treated as a header.
- If tvalid drops mid-packet, the state is held. Only handshaken beats count.
- Single-beat payload: header then one beat with tlast; the status word reflects that beat's popcount.

## Structure
- Package strip_header_pkg holds:
  - STAT_LEN_LSB/MSB, STAT_MISMATCH_BIT = 16, STAT_RUNT_BIT = 17, STAT_OVERFLOW_BIT = 18.
  - State encodings HDR = 0, PAYLOAD = 1.
  - Status width 32.
- One sub-module: keep_popcount, parameterised by DW/8. It is purely combinational and returns a $clog2(DW/8)+1-bit count.

## Test plan
- Header 0x0040, four full beats (tkeep all-ones, DW=128), tlast on the 4th:
  - 4 output beats, identical data.
  - Status = 0x0000_0040.
- Header 0x0025, beats with keep 0xFFFF, 0xFFFF, 0x001F:
  - Status = 0x0000_0025.
  - Then header 0x0030 with the same payload: status = 0x0001_0025 (MISMATCH).
- Header beat with tlast=1:
  - No output beat.
  - Status = 0x0002_0000.
  - The next beat is parsed as a header.
- axis_stat_tready held 0 after packet 1:
  - Packet 2's header is stalled (axis_in_tready = 0).
  - Releasing tready delivers status 1, and the header is accepted in the same cycle.
- Assert reset midway through a 4-beat packet:
  - All valids go to 0; no status word.
  - A following clean 0x0010 one-beat packet yields status 0x0000_0010.
- 4097 full beats (65552 bytes):
  - Status = 0x0005_FFFF (OVERFLOW and MISMATCH set, length saturated).

Source files
------------

// File: rtl/strip_header_pkg.sv
// Shared definitions for the header-stripping receive stage:
// status word layout, FSM states and the status-word builder.
package strip_header_pkg;

    localparam int STAT_W            = 32;
    localparam int STAT_LEN_LSB      = 0;
    localparam int STAT_LEN_MSB      = 15;
    localparam int STAT_MISMATCH_BIT = 16;
    localparam int STAT_RUNT_BIT     = 17;
    localparam int STAT_OVERFLOW_BIT = 18;

    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_t;

    // An overflowed packet can never match its declared length, so MISMATCH follows OVERFLOW.
    function automatic logic [STAT_W-1:0] build_status(
        input logic [15:0] len,
        input logic        mismatch,
        input logic        runt,
        input logic        overflow
    );
        logic [STAT_W-1:0] w;
        w                                  = '0;
        w[STAT_LEN_MSB:STAT_LEN_LSB]       = len;
        w[STAT_MISMATCH_BIT]               = mismatch | overflow;
        w[STAT_RUNT_BIT]                   = runt;
        w[STAT_OVERFLOW_BIT]               = overflow;
        return w;
    endfunction

endpackage

// File: rtl/strip_header_keep_popcount.sv
// Combinational count of set byte-enable bits; tkeep may be non-contiguous.
module keep_popcount #(
    parameter int KW = 16
) (
    input  logic [KW-1:0]        keep,
    output logic [$clog2(KW):0]  count
);

    localparam int CW = $clog2(KW) + 1;

    always_comb begin
        count = '0;
        for (int i = 0; i < KW; i++) begin
            count = count + CW'(keep[i]);
        end
    end

endmodule

// File: rtl/strip_header.sv
// Strips a one-beat length header from each packet, passes the payload straight
// through and reports declared-vs-measured length on a one-deep status stream.
module strip_header
    import strip_header_pkg::*;
#(
    parameter int DW = 128
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DW-1:0]       axis_in_tdata,
    input  logic [DW/8-1:0]     axis_in_tkeep,
    input  logic                axis_in_tlast,
    input  logic                axis_in_tvalid,
    output logic                axis_in_tready,
    output logic [DW-1:0]       axis_out_tdata,
    output logic [DW/8-1:0]     axis_out_tkeep,
    output logic                axis_out_tlast,
    output logic                axis_out_tvalid,
    input  logic                axis_out_tready,
    output logic [STAT_W-1:0]   axis_stat_tdata,
    output logic                axis_stat_tvalid,
    input  logic                axis_stat_tready
);

    localparam int KW = DW / 8;
    localparam int CW = $clog2(KW) + 1;

    state_t              state_reg, state_next;
    logic [16:0]         byte_cnt_reg, byte_cnt_next;
    logic [15:0]         exp_len_reg, exp_len_next;
    logic [STAT_W-1:0]   stat_reg, stat_word;
    logic                stat_valid_reg;
    logic                stat_load;

    logic [CW-1:0]       pop_cnt;
    logic [17:0]         final_sum;
    logic                overflow;
    logic [15:0]         len_sat;
    logic                mismatch;

    keep_popcount #(.KW(KW)) u_popcount (
        .keep  (axis_in_tkeep),
        .count (pop_cnt)
    );

    assign final_sum = {1'b0, byte_cnt_reg} + 18'(pop_cnt);
    assign overflow  = |final_sum[17:16];
    assign len_sat   = overflow ? 16'hFFFF : final_sum[15:0];
    assign mismatch  = overflow || (final_sum[15:0] != exp_len_reg);

    always_comb begin
        state_next      = state_reg;
        byte_cnt_next   = byte_cnt_reg;
        exp_len_next    = exp_len_reg;
        stat_load       = 1'b0;
        stat_word       = stat_reg;
        axis_in_tready  = 1'b0;
        axis_out_tdata  = '0;
        axis_out_tkeep  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tvalid = 1'b0;

        case (state_reg)
            HDR: begin
                // Headers wait for the status slot so a finished packet's word is never overwritten.
                axis_in_tready = !stat_valid_reg || axis_stat_tready;
                if (axis_in_tvalid && axis_in_tready) begin
                    exp_len_next  = axis_in_tdata[15:0];
                    byte_cnt_next = '0;
                    if (axis_in_tlast) begin
                        stat_load = 1'b1;
                        stat_word = build_status(16'd0, 1'b0, 1'b1, 1'b0);
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                axis_out_tdata  = axis_in_tdata;
                axis_out_tkeep  = axis_in_tkeep;
                axis_out_tlast  = axis_in_tlast;
                axis_out_tvalid = axis_in_tvalid;
                axis_in_tready  = axis_out_tready;
                if (axis_in_tvalid && axis_in_tready) begin
                    // Saturate so an extremely long packet keeps reporting overflow.
                    byte_cnt_next = final_sum[17] ? '1 : final_sum[16:0];
                    if (axis_in_tlast) begin
                        stat_load  = 1'b1;
                        stat_word  = build_status(len_sat, mismatch, 1'b0, overflow);
                        state_next = HDR;
                    end
                end
            end
        endcase

        if (reset) begin
            axis_in_tready  = 1'b0;
            axis_out_tdata  = '0;
            axis_out_tkeep  = '0;
            axis_out_tlast  = 1'b0;
            axis_out_tvalid = 1'b0;
            stat_load       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= HDR;
            byte_cnt_reg   <= '0;
            exp_len_reg    <= '0;
            stat_reg       <= '0;
            stat_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            exp_len_reg  <= exp_len_next;
            if (stat_load) begin
                stat_reg       <= stat_word;
                stat_valid_reg <= 1'b1;
            end else if (stat_valid_reg && axis_stat_tready) begin
                stat_valid_reg <= 1'b0;
            end
        end
    end

    assign axis_stat_tdata  = stat_reg;
    assign axis_stat_tvalid = stat_valid_reg && !reset;

endmodule

// File: tb/tb_strip_header.sv
// Directed bench for strip_header: a packet-level model predicts payload beats and
// status words, and one compare process checks every handshake against it.
module tb_strip_header;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] axis_in_tdata = '0;
    logic [15:0]  axis_in_tkeep = '0;
    logic         axis_in_tlast = 1'b0;
    logic         axis_in_tvalid = 1'b0;
    logic         axis_in_tready;
    logic [127:0] axis_out_tdata;
    logic [15:0]  axis_out_tkeep;
    logic         axis_out_tlast;
    logic         axis_out_tvalid;
    logic         axis_out_tready = 1'b1;
    logic [31:0]  axis_stat_tdata;
    logic         axis_stat_tvalid;
    logic         axis_stat_tready = 1'b1;

    int tests = 0;
    int fails = 0;
    logic out_rand = 1'b0;

    beat_t       exp_out[$];
    logic [31:0] exp_stat[$];
    logic [31:0] stat_log[$];

    strip_header #(.DW(128)) dut (
        .clk              (clk),
        .reset            (reset),
        .axis_in_tdata    (axis_in_tdata),
        .axis_in_tkeep    (axis_in_tkeep),
        .axis_in_tlast    (axis_in_tlast),
        .axis_in_tvalid   (axis_in_tvalid),
        .axis_in_tready   (axis_in_tready),
        .axis_out_tdata   (axis_out_tdata),
        .axis_out_tkeep   (axis_out_tkeep),
        .axis_out_tlast   (axis_out_tlast),
        .axis_out_tvalid  (axis_out_tvalid),
        .axis_out_tready  (axis_out_tready),
        .axis_stat_tdata  (axis_stat_tdata),
        .axis_stat_tvalid (axis_stat_tvalid),
        .axis_stat_tready (axis_stat_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [144:0] act, input logic [144:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected status from the packet's declared length and measured byte total.
    function automatic logic [31:0] model_status(input int exp_len, input int total);
        logic [31:0] s;
        s        = '0;
        s[15:0]  = (total > 65535) ? 16'hFFFF : total[15:0];
        s[16]    = (total != exp_len);
        s[18]    = (total > 65535);
        return s;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            axis_out_tready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Compare process: every output handshake and status handshake is checked.
    initial begin
        logic        prev_sv;
        logic        prev_acc;
        logic [31:0] prev_data;
        beat_t       b;
        prev_sv = 1'b0; prev_acc = 1'b0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_sv = 1'b0;
            end else begin
                if (axis_out_tvalid && axis_out_tready) begin
                    if (exp_out.size() == 0) begin
                        check("unexpected_out_beat", 145'(axis_out_tdata), 145'(0));
                        if (axis_out_tdata == 0) check("unexpected_out_beat_valid", 145'(axis_out_tvalid), 145'(0));
                    end else begin
                        b = exp_out.pop_front();
                        check("out_beat", {axis_out_tdata, axis_out_tkeep, axis_out_tlast}, b);
                    end
                end
                if (prev_sv && !prev_acc)
                    check("stat_hold", {axis_stat_tvalid, axis_stat_tdata}, {1'b1, prev_data});
                if (axis_stat_tvalid && axis_stat_tready) begin
                    stat_log.push_back(axis_stat_tdata);
                    if (exp_stat.size() == 0)
                        check("unexpected_status", 145'(axis_stat_tvalid), 145'(0));
                    else
                        check("status", 145'(axis_stat_tdata), 145'(exp_stat.pop_front()));
                end
                prev_sv   = axis_stat_tvalid;
                prev_acc  = axis_stat_tready;
                prev_data = axis_stat_tdata;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 2000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_beat(input logic [127:0] d, input logic [15:0] k, input logic l, output int waits);
        axis_in_tdata  = d;
        axis_in_tkeep  = k;
        axis_in_tlast  = l;
        axis_in_tvalid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            if (axis_in_tready) break;
            waits++;
            if (waits > 2000) begin
                tests++; fails++;
                $display("FAIL in_handshake_timeout: waited %0d cycles, limit 2000", waits);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_header(input logic [15:0] len, input logic last, output int waits);
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, 16'($urandom), len};
        if (last) exp_stat.push_back(32'h0002_0000);
        send_beat(d, 16'($urandom), last, waits);
    endtask

    task automatic send_payload(input int exp_len, input int n, input logic [15:0] klast);
        int total;
        int w;
        beat_t b;
        total = 0;
        for (int i = 0; i < n; i++) begin
            b.d = {$urandom, $urandom, $urandom, $urandom};
            b.k = (i == n - 1) ? klast : 16'hFFFF;
            b.l = (i == n - 1);
            total += $countones(b.k);
            exp_out.push_back(b);
            send_beat(b.d, b.k, b.l, w);
        end
        exp_stat.push_back(model_status(exp_len, total));
    endtask

    task automatic send_pkt(input logic [15:0] len, input int n, input logic [15:0] klast);
        int w;
        send_header(len, 1'b0, w);
        send_payload(int'(len), n, klast);
    endtask

    task automatic idle(input int n);
        axis_in_tvalid = 1'b0;
        axis_in_tlast  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        beat_t b;

        // Reset: drive a valid beat and confirm every output is held quiet.
        axis_in_tvalid = 1'b1;
        axis_in_tdata  = {4{32'hDEAD_BEEF}};
        axis_in_tkeep  = 16'hFFFF;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs",
                  {axis_in_tready, axis_out_tvalid, axis_stat_tvalid, axis_out_tlast, axis_out_tkeep, axis_out_tdata},
                  '0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        axis_in_tvalid = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {axis_in_tready, axis_stat_tvalid}, {1'b1, 1'b0});
        @(posedge clk); #1;

        send_pkt(16'h0040, 4, 16'hFFFF);
        send_pkt(16'h0025, 3, 16'h001F);
        send_pkt(16'h0030, 3, 16'h001F);
        send_header(16'h0077, 1'b1, w);
        send_pkt(16'h0010, 1, 16'hFFFF);
        send_pkt(16'h0005, 1, 16'h8421);
        out_rand = 1'b1;
        send_pkt(16'h0030, 3, 16'hFFFF);
        idle(2);
        out_rand = 1'b0;
        idle(2);

        // Status slot held: the next header must stall until the slot drains.
        axis_stat_tready = 1'b0;
        send_pkt(16'h0008, 1, 16'h00FF);
        idle(2);
        axis_in_tdata  = {112'h0, 16'h0010};
        axis_in_tlast  = 1'b0;
        axis_in_tvalid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("hdr_stall", {axis_in_tready, axis_stat_tvalid, axis_stat_tdata}, {1'b0, 1'b1, 32'h0000_0008});
        end
        @(posedge clk); #1;
        axis_stat_tready = 1'b1;
        send_header(16'h0010, 1'b0, w);
        check("hdr_release_same_cycle", 145'(w), 145'(0));
        send_payload(16'h0010, 1, 16'hFFFF);
        idle(4);

        // Reset mid-packet: two beats go out, then the packet is abandoned.
        send_header(16'h0040, 1'b0, w);
        for (int i = 0; i < 2; i++) begin
            b.d = {$urandom, $urandom, $urandom, $urandom};
            b.k = 16'hFFFF;
            b.l = 1'b0;
            exp_out.push_back(b);
            send_beat(b.d, b.k, b.l, w);
        end
        axis_in_tvalid = 1'b0;
        reset = 1'b1;
        axis_in_tvalid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("midpkt_reset_valids", {axis_in_tready, axis_out_tvalid, axis_stat_tvalid}, 3'b000);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        axis_in_tvalid = 1'b0;
        idle(2);
        send_pkt(16'h0010, 1, 16'hFFFF);

        // 4097 full beats: 65552 bytes, saturated and flagged.
        send_pkt(16'hFFFF, 4097, 16'hFFFF);
        idle(6);

        check("out_queue_drained", 145'(exp_out.size()), 145'(0));
        check("stat_queue_drained", 145'(exp_stat.size()), 145'(0));
        check("stat_count", 145'(stat_log.size()), 145'(11));
        if (stat_log.size() == 11) begin
            check("lit_full_pkt", 145'(stat_log[0]), 145'(32'h0000_0040));
            check("lit_partial_pkt", 145'(stat_log[1]), 145'(32'h0000_0025));
            check("lit_mismatch", 145'(stat_log[2]), 145'(32'h0001_0025));
            check("lit_runt", 145'(stat_log[3]), 145'(32'h0002_0000));
            check("lit_sparse_keep", 145'(stat_log[5]), 145'(32'h0001_0004));
            check("lit_stalled", 145'(stat_log[7]), 145'(32'h0000_0008));
            check("lit_after_reset", 145'(stat_log[9]), 145'(32'h0000_0010));
            check("lit_overflow", 145'(stat_log[10]), 145'(32'h0005_FFFF));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
